// File: rtl/op_sequencer_pkg.sv
// Shared types for the op_sequencer issue controller: operation word,
// mode encoding and the issue FSM state.
package op_sequencer_pkg;

   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      NO_OP        = 2'd0,
      OP_CT_CT_ADD = 2'd1,
      OP_CT_PT_ADD = 2'd2,
      OP_CT_PT_MUL = 2'd3
   } op_mode_t;

   typedef struct packed {
      op_mode_t             mode;
      logic [IDX_W-1:0]     idx1_a;
      logic [IDX_W-1:0]     idx1_b;
      logic [IDX_W-1:0]     idx2_a;
      logic [IDX_W-1:0]     idx2_b;
      logic [IDX_W-1:0]     out_a;
      logic [IDX_W-1:0]     out_b;
   } operation;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SETTLE = 2'd2
   } seq_state_t;

   function automatic logic is_real_op(operation o);
      return o.mode != NO_OP;
   endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Host push handshake plus the cpu op/done pair, bundled for the sequencer.
interface op_sequencer_if;
   import op_sequencer_pkg::*;

   logic     in_valid;
   logic     in_ready;
   operation in_op;
   operation cpu_op;
   logic     cpu_done;

   modport master (output in_valid, in_op, cpu_done, input in_ready, cpu_op);
   modport slave  (input in_valid, in_op, cpu_done, output in_ready, cpu_op);
endinterface

// File: rtl/op_sequencer_fifo.sv
// Operation FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable when the index bits match.
module op_fifo
   import op_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  operation din,
   output operation head,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, rd_q;
   operation    mem [DEPTH];
   logic        do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= din;
   end

   assign head  = mem[rd_q[AW-1:0]];
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/op_sequencer.sv
// Issues buffered operations to the cpu one at a time: one-cycle op pulse,
// wait for done, one settle cycle, retire; watchdog drops stuck ops.
module op_sequencer
   import op_sequencer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 500
) (
   input  logic                clk,
   input  logic                reset,
   op_sequencer_if.slave       bus,
   input  logic                clr_err,
   output logic                busy,
   output logic                err_timeout,
   output logic [15:0]         retired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   seq_state_t    state_q, state_d;
   logic [CW-1:0] wcnt_q;
   operation      cpu_op_q, head;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic          do_issue, do_retire, do_drop, cnt_inc;

   // NO_OP words complete the handshake but never reach the queue.
   assign fifo_push    = bus.in_valid && !fifo_full && is_real_op(bus.in_op);
   assign fifo_pop     = do_retire || do_drop;
   assign bus.in_ready = !fifo_full;
   assign bus.cpu_op   = cpu_op_q;
   assign busy         = (state_q != IDLE) || !fifo_empty;

   op_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.in_op),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      do_issue  = 1'b0;
      do_retire = 1'b0;
      do_drop   = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               do_issue = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // A zero count marks the issue-pulse edge, where done is not yet meaningful.
            if (wcnt_q != '0 && bus.cpu_done) begin
               state_d = SETTLE;
            end else if (wcnt_q == CNT_LAST) begin
               do_drop = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SETTLE: begin
            do_retire = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_op_q    <= '0;
         wcnt_q      <= '0;
         err_timeout <= 1'b0;
         retired     <= '0;
      end else begin
         if (do_issue) begin
            cpu_op_q <= head;
            wcnt_q   <= '0;
         end else if (state_q == WAIT) begin
            cpu_op_q.mode <= NO_OP;
         end
         if (cnt_inc) wcnt_q <= wcnt_q + 1'b1;
         if (do_drop)      err_timeout <= 1'b1;
         else if (clr_err) err_timeout <= 1'b0;
         if (do_retire) retired <= retired + 16'd1;
      end
   end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Issue controller that sits in front of `cpu` and drives its `op` input. It accepts a stream of `operation` words from a host through a valid/ready handshake and buffers them in a small FIFO. It issues them to `cpu` one at a time, presenting each for exactly one cycle, then holds `NO_OP` until `done_out`, allows one writeback-settle cycle, and retires the entry. A watchdog drops operations that never complete and flags a sticky error.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 500: maximum number of WAIT cycles without `done_out` before the operation is dropped.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `in_valid`  in  1  host presents `in_op`.
- `in_ready`  out  1  `!full`; transfer occurs on a rising edge with `in_valid && in_ready`.
- `in_op`  in  `$bits(operation)`  operation word (`mode`, `idx1_a`, `idx1_b`, `idx2_a`, `idx2_b`, `out_a`, `out_b`).
- `cpu_op`  out  `$bits(operation)`  registered; drives `cpu.op`.
- `cpu_done`  in  1  `cpu.done_out`.
- `clr_err`  in  1  clears `err_timeout`.
- `busy`  out  1  `state != IDLE || !empty`.
- `err_timeout`  out  1  sticky watchdog flag.
- `retired`  out  16  count of completed operations; wraps 0xFFFF→0.

## Operation
- Reset values: `cpu_op` = all zeros with `mode = NO_OP`. `in_ready = 1`, `busy = 0`, `err_timeout = 0`, `retired = 0`. FIFO empty; `state = IDLE`.
- Push: a word with `mode == NO_OP` is accepted (`in_ready` honoured) but discarded. It is not enqueued and not counted.
- `in_ready` depends only on `full`. There is no same-cycle bypass when full, even if a pop occurs in that cycle. A push and a pop in the same cycle are both performed.
- States:
  - IDLE: if FIFO is non-empty, `cpu_op <= head`, clear the wait counter, go to WAIT. Otherwise stay.
  - WAIT:
    - On the first edge, `cpu_op.mode <= NO_OP`. The other `cpu_op` fields hold the issued values until the next issue.
    - `cpu_done` is ignored on that first edge. On every later edge, `cpu_done = 1` moves to SETTLE.
    - Otherwise the counter increments. When the counter equals `TIMEOUT-1` and `cpu_done` is low: set `err_timeout`, pop the head, do not increment `retired`, go to IDLE.
  - SETTLE: pop the head, `retired <= retired + 1`, go to IDLE.
- `clr_err` and a timeout on the same edge: set wins.
- Reset asserted mid-operation: FIFO contents are lost and `cpu_op` returns to `NO_OP` asynchronously. No partial retire.

## Timing
- Push accepted on edge E0. Issue occurs on E1, so `cpu_op.mode` is valid during cycle E1–E2 only. `cpu_op.mode = NO_OP` from E2.
- Earliest done sample is E3, giving SETTLE. Pop and retire occur on E4. The next issue occurs on E5.
- Minimum back-to-back issue period: 4 cycles.
- `retired` and `in_ready` update on the SETTLE edge. A full FIFO reopens (`in_ready = 1`) in the cycle after the pop.
- Timeout drop occurs exactly `TIMEOUT` edges after entering WAIT.
- All outputs are registered or decoded from registered state; there is no combinational path from `cpu_done` or `in_valid`.

## Structure
- Shared package (`types.svh`): `operation` and the mode enum (`NO_OP`, `OP_CT_CT_ADD`, `OP_CT_PT_ADD`, `OP_CT_PT_MUL`) already live there. Add `seq_state_t {IDLE, WAIT, SETTLE}`.
- Sub-module `op_fifo` (parameter `DEPTH`, payload `operation`):
  - read/write pointers of `$clog2(DEPTH)+1` bits, with an extra wrap bit distinguishing full from empty;
  - `push`, `pop`, `head`, `full`, `empty`.
- Wait counter width: `$clog2(TIMEOUT+1)`.

## Test plan
- **Reset:** hold `reset = 0` for 2 cycles → `cpu_op.mode = NO_OP`, `busy = 0`, `retired = 0`, `in_ready = 1`.
- **Single add:** push `OP_CT_CT_ADD` with idx 0/1/2/3 → 5/6. Model returns `cpu_done` 3 cycles after issue. Check `cpu_op.mode = OP_CT_CT_ADD` for exactly 1 cycle, then `NO_OP`, with `out_a = 5` held. Check `retired = 1` two edges after done.
- **Back-to-back:** push CT-CT ADD, CT-PT ADD, CT-PT MUL with `cpu_done` on the first legal edge. Check issue edges are 4 cycles apart, the issue order matches push order, and `retired = 3`.
- **Full / back-pressure:** with `DEPTH = 4` and `cpu_done` held low, push 5 words → 5th stalls with `in_ready = 0`. Release done → 5th accepted one cycle after the first pop.
- **NO_OP filter:** push `NO_OP` then `OP_CT_PT_ADD` → only the add is issued; `retired = 1`.
- **Watchdog:** with `TIMEOUT = 8` and done never returned, `err_timeout` rises on the 8th WAIT edge, `retired` is unchanged, and the next op issues. `clr_err` clears the flag. Asserting `reset = 0` mid-WAIT returns everything to reset values.
